// File: rtl/traffic_light_nway_if.sv
// ----------------------------------------------------------------------------
// traffic_light_nway_if
//   Groups the signals between the N-way traffic-light controller and the
//   intersection environment. Clock and reset are kept outside the interface.
//
//   master : controller side (takes en/ped_req, drives the lamps and status)
//   slave  : environment side (drives en/ped_req, observes lamps and status)
//
//   en       tick enable; controller state advances only when en=1
//   ped_req  pedestrian button, level or pulse
//   red      red lamp per approach    (NUM_DIR bits)
//   yellow   yellow lamp per approach (NUM_DIR bits)
//   green    green lamp per approach  (NUM_DIR bits)
//   walk     pedestrian WALK lamp
//   phase    approach currently owning green/yellow
//   ped_wait pedestrian request latched, not yet served
// ----------------------------------------------------------------------------
interface traffic_light_nway_if #(
   parameter int NUM_DIR = 3
);
   localparam int PH_W = $clog2(NUM_DIR);

   logic               en;
   logic               ped_req;
   logic [NUM_DIR-1:0] red;
   logic [NUM_DIR-1:0] yellow;
   logic [NUM_DIR-1:0] green;
   logic               walk;
   logic [PH_W-1:0]    phase;
   logic               ped_wait;

   modport master (
      input  en, ped_req,
      output red, yellow, green, walk, phase, ped_wait
   );

   modport slave (
      output en, ped_req,
      input  red, yellow, green, walk, phase, ped_wait
   );
endinterface

// File: rtl/traffic_light_nway.sv
// ----------------------------------------------------------------------------
// traffic_light_nway
//   N-direction traffic-light controller. Green rotates round-robin over
//   NUM_DIR approaches: green -> yellow -> all-red clearance, with an optional
//   pedestrian WALK phase inserted after the all-red when a request is latched.
//   Durations are counted in enabled (en=1) clock cycles.
//
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-low reset
//   bus    traffic_light_nway_if.master: en, ped_req in; red/yellow/green,
//          walk, phase, ped_wait out (Moore-decoded, no extra latency)
// ----------------------------------------------------------------------------
module traffic_light_nway #(
   parameter int NUM_DIR      = 3,
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   traffic_light_nway_if.master        bus
);

   localparam int MAX_GY = (GREEN_TICKS  > YELLOW_TICKS) ? GREEN_TICKS  : YELLOW_TICKS;
   localparam int MAX_AW = (ALLRED_TICKS > WALK_TICKS)   ? ALLRED_TICKS : WALK_TICKS;
   localparam int MAX_T  = (MAX_GY > MAX_AW) ? MAX_GY : MAX_AW;
   localparam int CNT_W  = $clog2(MAX_T) + 1;
   localparam int PH_W   = $clog2(NUM_DIR);

   typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_WALK} state_t;

   state_t             state,    state_nx;
   logic [PH_W-1:0]    phase_q,  phase_nx;
   logic [CNT_W-1:0]   timer,    timer_nx;
   logic               ped_pend, ped_nx;
   logic [PH_W-1:0]    phase_next;
   logic [NUM_DIR-1:0] sel;

   assign phase_next = (phase_q == PH_W'(NUM_DIR - 1)) ? '0 : phase_q + PH_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_GREEN;
         phase_q  <= '0;
         timer    <= CNT_W'(GREEN_TICKS - 1);
         ped_pend <= 1'b0;
      end else begin
         state    <= state_nx;
         phase_q  <= phase_nx;
         timer    <= timer_nx;
         ped_pend <= ped_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      phase_nx = phase_q;
      timer_nx = timer;
      ped_nx   = ped_pend;

      // Button is latched regardless of en; presses during WALK are ignored.
      if (bus.ped_req && (state != S_WALK))
         ped_nx = 1'b1;

      if (bus.en) begin
         if (timer != '0) begin
            timer_nx = timer - CNT_W'(1);
         end else begin
            unique case (state)
               S_GREEN: begin
                  state_nx = S_YELLOW;
                  timer_nx = CNT_W'(YELLOW_TICKS - 1);
               end
               S_YELLOW: begin
                  state_nx = S_ALLRED;
                  timer_nx = CNT_W'(ALLRED_TICKS - 1);
               end
               S_ALLRED: begin
                  if (ped_pend) begin
                     // Entering WALK serves the request, including a press on this same edge.
                     state_nx = S_WALK;
                     timer_nx = CNT_W'(WALK_TICKS - 1);
                     ped_nx   = 1'b0;
                  end else begin
                     state_nx = S_GREEN;
                     phase_nx = phase_next;
                     timer_nx = CNT_W'(GREEN_TICKS - 1);
                  end
               end
               S_WALK: begin
                  state_nx = S_GREEN;
                  phase_nx = phase_next;
                  timer_nx = CNT_W'(GREEN_TICKS - 1);
               end
               default: begin
                  state_nx = S_GREEN;
                  timer_nx = CNT_W'(GREEN_TICKS - 1);
               end
            endcase
         end
      end
   end

   // Output decode
   assign sel = NUM_DIR'(1) << phase_q;

   always_comb begin
      bus.red    = '1;
      bus.yellow = '0;
      bus.green  = '0;
      bus.walk   = 1'b0;
      unique case (state)
         S_GREEN: begin
            bus.green = sel;
            bus.red   = ~sel;
         end
         S_YELLOW: begin
            bus.yellow = sel;
            bus.red    = ~sel;
         end
         S_WALK:   bus.walk = 1'b1;
         default:  ;
      endcase
   end

   assign bus.phase    = phase_q;
   assign bus.ped_wait = ped_pend;

endmodule
